// File: rtl/board_loader.sv
// Front-panel data entry: debounces three push buttons, assembles a 16-bit word
// from hex digits on the switches, and strobes it into the CPU load port.
module board_loader #(
  parameter int DB_BITS = 20,
  parameter int DB_MAX  = 500000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  sw,
  input  logic        btn_enter,
  input  logic        btn_write,
  input  logic        btn_clear,
  output logic        load_en,
  output logic [7:0]  load_addr,
  output logic [15:0] load_data,
  output logic [15:0] entry,
  output logic [2:0]  digits
);

  localparam logic [DB_BITS-1:0] CntLast = DB_BITS'(DB_MAX - 1);

  localparam int BtnEnter = 0;
  localparam int BtnWrite = 1;
  localparam int BtnClear = 2;

  logic [2:0]         btnRaw;
  logic [2:0]         sync1_q;
  logic [2:0]         sync2_q;
  logic [2:0]         db_q;
  logic [2:0]         press_q;
  logic [DB_BITS-1:0] cnt_q [3];

  logic [15:0] entry_q, entry_d;
  logic [2:0]  digits_q, digits_d;
  logic [7:0]  addr_q, addr_d;
  logic        loadEn_q, loadEn_d;
  logic [7:0]  loadAddr_q, loadAddr_d;
  logic [15:0] loadData_q, loadData_d;

  assign btnRaw = {btn_clear, btn_write, btn_enter};

  // Press pulse is registered in the same cycle the debounced level rises.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      press_q <= '0;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= btnRaw;
      sync2_q <= sync1_q;
      for (int i = 0; i < 3; i++) begin
        press_q[i] <= 1'b0;
        if (sync2_q[i] == db_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CntLast) begin
          cnt_q[i]   <= '0;
          db_q[i]    <= sync2_q[i];
          press_q[i] <= sync2_q[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    entry_d    = entry_q;
    digits_d   = digits_q;
    addr_d     = addr_q;
    loadEn_d   = 1'b0;
    loadAddr_d = loadAddr_q;
    loadData_d = loadData_q;
    if (press_q[BtnClear]) begin
      entry_d  = '0;
      digits_d = '0;
    end else if (press_q[BtnWrite]) begin
      if (digits_q == 3'd4) begin
        loadEn_d   = 1'b1;
        loadAddr_d = addr_q;
        loadData_d = entry_q;
        entry_d    = '0;
        digits_d   = '0;
        addr_d     = addr_q + 8'd1;
      end
    end else if (press_q[BtnEnter]) begin
      if (digits_q != 3'd4) begin
        entry_d  = {entry_q[11:0], sw};
        digits_d = digits_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      entry_q    <= '0;
      digits_q   <= '0;
      addr_q     <= '0;
      loadEn_q   <= 1'b0;
      loadAddr_q <= '0;
      loadData_q <= '0;
    end else begin
      entry_q    <= entry_d;
      digits_q   <= digits_d;
      addr_q     <= addr_d;
      loadEn_q   <= loadEn_d;
      loadAddr_q <= loadAddr_d;
      loadData_q <= loadData_d;
    end
  end

  assign load_en   = loadEn_q;
  assign load_addr = loadAddr_q;
  assign load_data = loadData_q;
  assign entry     = entry_q;
  assign digits    = digits_q;

endmodule

// File: doc/board_loader.md
# board_loader

Front-panel data-entry block for the on-board CPU build: it reads the 4-bit switch bank and three raw push buttons, builds a 16-bit word one hex digit at a time, and writes that word into the CPU's external load port as a single-cycle strobe with an auto-incrementing 8-bit address. It fills the CPU's external load inputs, which are otherwise tied off in the board top. It also exports the word being entered so the 7-segment display can echo it.

## Interface
Parameters:
- DB_BITS, 20: width of each debounce counter.
- DB_MAX, 500000: consecutive stable cycles needed to accept a button level change (10 ms at 50 MHz); must be ≥2 and < 2^DB_BITS.

Ports:
- clock  in  1  system clock; one clock; all state on its rising edge.
- reset  in  1  reset, asynchronous and active-high.
- sw  in  4  hex digit from the slide switches; sampled on an accepted enter press.
- btn_enter  in  1  raw push button, asynchronous, bouncy; shifts `sw` in as a digit.
- btn_write  in  1  raw push button; commits the completed word to the CPU.
- btn_clear  in  1  raw push button; discards the partial word.
- load_en  out  1  one-cycle write strobe to the CPU load port.
- load_addr  out  8  write address; valid while `load_en`=1.
- load_data  out  16  write data; valid while `load_en`=1.
- entry  out  16  word under construction, for the display.
- digits  out  3  number of digits entered, 0–4.

## Operation
**Button conditioning** (identical per button):
- Two-flop synchronizer, then a debouncer holding a debounced level `db` (reset 0).
- The counter counts consecutive cycles in which the synchronized input ≠ `db`. It clears on any cycle they are equal.
- After DB_MAX consecutive mismatch cycles, `db` takes the new value and the counter clears.
- A rising edge of `db` produces a one-cycle press pulse. Release generates no pulse.
- A bounce shorter than DB_MAX never produces a pulse.

**Entry state** consists of `entry`, `digits` and an address register `addr`. Press handling, in priority order when pulses coincide on the same cycle (clear > write > enter; lower-priority pulses that cycle are dropped):
- **clear:** `entry` ← 0, `digits` ← 0; `addr` unchanged.
- **write:**
  - If `digits`=4: `load_en`=1 for exactly one cycle, `load_data`=`entry`, `load_addr`=`addr`.
  - On that same edge: `entry` ← 0, `digits` ← 0, `addr` ← `addr`+1 mod 256 (255 wraps to 0).
  - If `digits`<4: ignored, with no strobe and no state change.
- **enter:**
  - If `digits`<4: `entry` ← {`entry`[11:0], `sw`}, `digits` ← `digits`+1.
  - If `digits`=4: ignored (the word is full until a write or clear).

**Outputs:**
- `load_addr`/`load_data` are registered and hold their last written values between strobes.
- `entry`/`digits` are registered directly from state.

**Reset:**
- Immediate, asynchronous: all outputs 0, `addr` 0, synchronizers, counters and `db` cleared.
- Reset mid-strobe aborts the strobe.
- A button held through reset release is treated as a new press: one pulse after debounce.

## Timing
- Press latency: after a clean raw rising edge, the `entry`/`digits`/strobe update appears between DB_MAX+2 and DB_MAX+4 clock edges later. The exact figure is implementation-fixed and must be constant.
- `load_en` is high for exactly one cycle per accepted write and never on two consecutive cycles. Minimum spacing between strobes is 2·DB_MAX cycles (press plus release).
- There is no backpressure: the CPU must accept a strobe on any cycle.
- The `sw` value captured is the one present on the cycle the enter pulse is acted on. `sw` is treated as quasi-static and is not synchronized.

## Test plan
All scenarios use DB_MAX=4.
- **Entry and write.** Reset; then enter digits with `sw`=1, 2, 3, 4 (clean presses); then write. Required: `entry` goes 0x0001, 0x0012, 0x0123, 0x1234 and `digits` counts 1–4; one strobe with `load_addr`=0x00, `load_data`=0x1234; then `entry`=0, `digits`=0, next address 0x01.
- **Bounce rejection.** Toggle `btn_enter` with 3-cycle glitches for 20 cycles, then hold it stable. Required: exactly one digit accepted; no pulse during the glitching.
- **Overflow and early write.** Enter 5 digits (A, B, C, D, E). Required: `entry`=0xABCD, `digits`=4. Then clear, enter 2 digits and write. Required: no strobe, `digits` stays 2.
- **Address wrap.** Perform 257 complete writes. Required: `load_addr` runs 0x00…0xFF, then 0x00; each `load_en` lasts exactly one cycle.
- **Simultaneous presses.** Press clear, write and enter in the same cycle with `digits`=4. Required: no strobe, `entry`=0, `digits`=0, `addr` unchanged.
- **Mid-operation reset.** Assert reset with `digits`=3 and `btn_enter` held. Required: all outputs 0 immediately. After release, one digit is accepted after the debounce latency.
